alu_psubsb_seq: RTL

Lane-serial packed saturating subtractor for the WISC ALU, the subtract counterpart of the packed saturating nibble adder. It latches two 16-bit operands on a start pulse, then computes one signed 4-bit lane per cycle using a single shared 4-bit subtract datapath. Results saturate per lane. A one-cycle done pulse signals completion to the execute-stage controller.

---
 rtl/alu_psubsb_seq_if.sv | 17 +
 rtl/alu_psubsb_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_psubsb_seq_if.sv
// Operand/result bus for the lane-serial packed saturating subtractor.
interface alu_psubsb_seq_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 4
) ();
  logic             start;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             busy;
  logic             done;
  logic [W-1:0]     S;
  logic [LANES-1:0] sat;
  logic             ovf;

  modport master (output start, A, B, input busy, done, S, sat, ovf);
  modport slave  (input start, A, B, output busy, done, S, sat, ovf);
endinterface

// File: rtl/alu_psubsb_seq.sv
// Lane-serial packed saturating subtractor: one signed lane per cycle through
// a single shared subtract datapath, saturating per lane.
module alu_psubsb_seq #(
  parameter int unsigned LANE_W = 4,
  parameter int unsigned LANES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_psubsb_seq_if.slave    bus
);
  localparam int unsigned W     = LANE_W * LANES;
  localparam int unsigned CNT_W = $clog2(LANES);
  localparam int unsigned IDX_W = $clog2(W);
  localparam int unsigned MSB   = LANE_W - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     s_q, s_d;
  logic [LANES-1:0] sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0]  base;
  logic [LANE_W-1:0] a_l, b_l, diff, res;
  logic              lane_ovf;

  // Shared lane datapath: select the current lane, subtract, saturate.
  always_comb begin
    base     = IDX_W'(cnt_q) * IDX_W'(LANE_W);
    a_l      = a_q[base +: LANE_W];
    b_l      = b_q[base +: LANE_W];
    diff     = a_l + ~b_l + LANE_W'(1);
    lane_ovf = (a_l[MSB] != b_l[MSB]) && (diff[MSB] != a_l[MSB]);
    if (!lane_ovf) begin
      res = diff;
    end else if (a_l[MSB]) begin
      res = {1'b1, {(LANE_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(LANE_W-1){1'b1}}};
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    // busy trails the lane commits by one cycle; a start taken in DONE keeps
    // it asserted so chained operations show no gap.
    busy_d  = (state_q == RUN);
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          s_d     = '0;
          sat_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
          if (state_q == DONE) begin
            busy_d = 1'b1;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[base +: LANE_W] = res;
        sat_d[cnt_q]        = lane_ovf;
        ovf_d               = ovf_q | lane_ovf;
        cnt_d               = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LANES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sat_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.S    = s_q;
  assign bus.sat  = sat_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
